// File: rtl/fetch_pkg.sv
// Shared types, constants and the PC legality check for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // Legal means word aligned, no bits above the word address, and a populated word index.
    function automatic logic pc_legal(input logic [PC_W-1:0] pc,
                                      input int unsigned addr_w,
                                      input int unsigned imem_depth);
        logic [PC_W-1:0] word;
        word = pc >> 2;
        return (pc[1:0] == 2'b00) && ((word >> addr_w) == '0) && (word < imem_depth);
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating fetch/stall counter pair for the fetch stage (built only with FETCH_PERF_EN).
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch_inc && (fetch_cnt != 32'hFFFF_FFFF))
                fetch_cnt <= fetch_cnt + 32'd1;
            if (stall_inc && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the instruction memory and holds the IR for decode.
// Optional macro FETCH_PERF_EN adds fetch_cnt/stall_cnt performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned IMEM_DEPTH = 12,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              instr_ack,
    input  logic              redirect_valid,
    input  logic [WIDTH-1:0]  redirect_pc,
    output logic [ADDR_W-1:0] imem_adr,
    input  logic [WIDTH-1:0]  imem_data,
    output logic [WIDTH-1:0]  pc,
    output logic [WIDTH-1:0]  pc_plus4,
    output logic [WIDTH-1:0]  instr,
    output logic              instr_valid,
    output logic              fault,
    output logic [1:0]        dbg_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    // Handshake: fetch_req is sampled only in IDLE and starts one fetch; instr_valid stays
    // high with instr/pc frozen until a cycle with instr_ack=1 consumes it (ack ignored otherwise).

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, ir_q;
    logic             pc_load, capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = redirect_pc;
        pc_load = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = pc_legal(PC_W'(redirect_pc), ADDR_W, IMEM_DEPTH) ? IDLE : FAULT;
                end else if (fetch_req) begin
                    state_d = pc_legal(PC_W'(pc_q), ADDR_W, IMEM_DEPTH) ? FETCH : FAULT;
                end
            end
            FETCH: begin
                // A redirect squashes the in-flight read instead of capturing it.
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = pc_legal(PC_W'(redirect_pc), ADDR_W, IMEM_DEPTH) ? IDLE : FAULT;
                end else begin
                    capture = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (instr_ack) begin
                    pc_load = 1'b1;
                    pc_d    = redirect_valid ? redirect_pc : pc_plus4;
                    state_d = pc_legal(PC_W'(pc_d), ADDR_W, IMEM_DEPTH) ? IDLE : FAULT;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
            ir_q <= WIDTH'(NOP_INSTR);
        end else begin
            if (pc_load) pc_q <= pc_d;
            if (capture) ir_q <= imem_data;
        end
    end

    always_comb begin
        instr_valid = (state_q == VALID);
        fault       = (state_q == FAULT);
        instr       = (state_q == FAULT) ? WIDTH'(NOP_INSTR) : ir_q;
    end

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + WIDTH'(4);
    assign imem_adr  = pc_q[ADDR_W+1:2];
    assign dbg_state = state_q;

`ifdef FETCH_PERF_EN
    fetch_perf_cnt u_perf (
        .clk       (clk),
        .rst       (rst),
        .fetch_inc (capture),
        .stall_inc ((state_q == VALID) && !instr_ack),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for the main flow plus hand-written corner sequences.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic        instr_ack = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [6:0]  imem_adr;
    logic [31:0] imem_data;
    logic [31:0] pc, pc_plus4, instr;
    logic        instr_valid, fault;
    logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Word i holds addi x1,x0,7+i, so word 0 is 32'h00700093.
    always_comb begin
        if (imem_adr < 7'd12) imem_data = 32'h00700093 + ({25'b0, imem_adr} << 20);
        else                  imem_data = 32'hDEADBEEF;
    end

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req      (fetch_req),
        .instr_ack      (instr_ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_adr       (imem_adr),
        .imem_data      (imem_data),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .fault          (fault),
        .dbg_state      (dbg_state)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    typedef struct {
        logic        req, ack, rv;
        logic [31:0] rpc;
        logic [31:0] e_pc;
        logic [6:0]  e_adr;
        logic [31:0] e_instr;
        logic        e_valid, e_fault;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic req, logic ack, logic rv, logic [31:0] rpc,
                                logic [31:0] e_pc, logic [6:0] e_adr, logic [31:0] e_instr,
                                logic e_valid, logic e_fault, logic [1:0] e_state);
        vec_t v;
        v.req = req; v.ack = ack; v.rv = rv; v.rpc = rpc;
        v.e_pc = e_pc; v.e_adr = e_adr; v.e_instr = e_instr;
        v.e_valid = e_valid; v.e_fault = e_fault; v.e_state = e_state;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic req, input logic ack, input logic rv, input logic [31:0] rpc);
        fetch_req = req; instr_ack = ack; redirect_valid = rv; redirect_pc = rpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic e_valid, input logic e_fault, input logic [1:0] e_state);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
        check({tag, ".imem_adr"}, {25'b0, imem_adr}, {25'b0, e_pc[8:2]});
        check({tag, ".instr"}, instr, e_instr);
        check({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, e_valid});
        check({tag, ".fault"}, {31'b0, fault}, {31'b0, e_fault});
        check({tag, ".state"}, {30'b0, dbg_state}, {30'b0, e_state});
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, '0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        //               req ack rv rpc        pc      adr   instr         v  f  st
        vecs[0]  = mk(0, 0, 0, 32'h00, 32'h00, 7'd0, NOP,          0, 0, 2'd0);
        vecs[1]  = mk(1, 0, 0, 32'h00, 32'h00, 7'd0, NOP,          0, 0, 2'd1);
        vecs[2]  = mk(0, 0, 0, 32'h00, 32'h00, 7'd0, 32'h00700093, 1, 0, 2'd2);
        vecs[3]  = mk(0, 0, 0, 32'h00, 32'h00, 7'd0, 32'h00700093, 1, 0, 2'd2);
        vecs[4]  = mk(0, 1, 0, 32'h00, 32'h04, 7'd1, 32'h00700093, 0, 0, 2'd0);
        vecs[5]  = mk(1, 0, 0, 32'h00, 32'h04, 7'd1, 32'h00700093, 0, 0, 2'd1);
        vecs[6]  = mk(0, 0, 0, 32'h00, 32'h04, 7'd1, 32'h00800093, 1, 0, 2'd2);
        vecs[7]  = mk(0, 1, 1, 32'h14, 32'h14, 7'd5, 32'h00800093, 0, 0, 2'd0);
        vecs[8]  = mk(1, 0, 0, 32'h00, 32'h14, 7'd5, 32'h00800093, 0, 0, 2'd1);
        vecs[9]  = mk(0, 0, 0, 32'h00, 32'h14, 7'd5, 32'h00C00093, 1, 0, 2'd2);
        vecs[10] = mk(0, 1, 1, 32'h08, 32'h08, 7'd2, 32'h00C00093, 0, 0, 2'd0);
        vecs[11] = mk(1, 0, 0, 32'h00, 32'h08, 7'd2, 32'h00C00093, 0, 0, 2'd1);
        vecs[12] = mk(0, 0, 1, 32'h10, 32'h10, 7'd4, 32'h00C00093, 0, 0, 2'd0);
        vecs[13] = mk(0, 1, 0, 32'h00, 32'h10, 7'd4, 32'h00C00093, 0, 0, 2'd0);
        vecs[14] = mk(1, 0, 1, 32'h0C, 32'h0C, 7'd3, 32'h00C00093, 0, 0, 2'd0);
        vecs[15] = mk(1, 0, 0, 32'h00, 32'h0C, 7'd3, 32'h00C00093, 0, 0, 2'd1);
        vecs[16] = mk(1, 0, 0, 32'h00, 32'h0C, 7'd3, 32'h00A00093, 1, 0, 2'd2);
        vecs[17] = mk(0, 1, 0, 32'h00, 32'h10, 7'd4, 32'h00A00093, 0, 0, 2'd0);

        do_reset();
        check_all("reset", 32'h0, NOP, 1'b0, 1'b0, 2'd0);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].req, vecs[i].ack, vecs[i].rv, vecs[i].rpc);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                      vecs[i].e_valid, vecs[i].e_fault, vecs[i].e_state);
            check($sformatf("vec%0d.adr_tbl", i), {25'b0, imem_adr}, {25'b0, vecs[i].e_adr});
        end

        // Stall: five unacknowledged cycles at pc 0x10, then a single +4 advance.
        drive(1'b1, 1'b0, 1'b0, '0); step();
        drive(1'b0, 1'b0, 1'b0, '0); step();
        check_all("stall.cap", 32'h10, 32'h00B00093, 1'b1, 1'b0, 2'd2);
        for (int i = 0; i < 5; i++) begin
            step();
            check_all($sformatf("stall%0d", i), 32'h10, 32'h00B00093, 1'b1, 1'b0, 2'd2);
        end
`ifdef FETCH_PERF_EN
        check("perf.stall_cnt", stall_cnt, 32'd6);
        check("perf.fetch_cnt", fetch_cnt, 32'd5);
`endif
        drive(1'b0, 1'b1, 1'b0, '0); step();
        check_all("stall.ack", 32'h14, 32'h00B00093, 1'b0, 1'b0, 2'd0);

        // Last populated word, then sequential advance onto word 12 faults.
        drive(1'b0, 1'b0, 1'b1, 32'h2C); step();
        check_all("last.redir", 32'h2C, 32'h00B00093, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, '0); step();
        drive(1'b0, 1'b0, 1'b0, '0); step();
        check_all("last.cap", 32'h2C, 32'h01200093, 1'b1, 1'b0, 2'd2);
        drive(1'b0, 1'b1, 1'b0, '0); step();
        check_all("range.fault", 32'h30, NOP, 1'b0, 1'b1, 2'd3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 32'h0); step();
            check_all($sformatf("fault.hold%0d", i), 32'h30, NOP, 1'b0, 1'b1, 2'd3);
        end

        do_reset();
        check_all("reset2", 32'h0, NOP, 1'b0, 1'b0, 2'd0);
`ifdef FETCH_PERF_EN
        check("perf.reset_fetch", fetch_cnt, 32'd0);
        check("perf.reset_stall", stall_cnt, 32'd0);
`endif
        drive(1'b0, 1'b0, 1'b1, 32'h06); step();
        check_all("misalign", 32'h06, NOP, 1'b0, 1'b1, 2'd3);

        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h30); step();
        check_all("redir.word12", 32'h30, NOP, 1'b0, 1'b1, 2'd3);

        do_reset();
        drive(1'b1, 1'b0, 1'b1, 32'h200); step();
        check_all("upper_bits", 32'h200, NOP, 1'b0, 1'b1, 2'd3);

        // Asynchronous reset landing between edges of a FETCH cycle.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h08); step();
        drive(1'b1, 1'b0, 1'b0, '0); step();
        check_all("async.fetch", 32'h08, NOP, 1'b0, 1'b0, 2'd1);
        #1 rst = 1'b0;
        #1;
        check_all("async.now", 32'h0, NOP, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        rst = 1'b1;
        step();
        check_all("async.after", 32'h0, NOP, 1'b0, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the multi-cycle core; sits directly upstream of the instruction memory and downstream of the control FSM.
- Owns the PC, drives the word address into the combinational-read instruction memory, and captures the returned word into an instruction register (IR).
- Holds the IR stable for decode until the control FSM acknowledges it. Accepts PC redirects from branch resolution.

Parameters:
- WIDTH, 32, instruction/PC data width
- ADDR_W, 7, instruction-memory word-address width
- IMEM_DEPTH, 12, number of populated instruction words; word index >= IMEM_DEPTH is a fault
- RESET_PC, 32'h0, byte PC loaded on reset

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- fetch_req  in  1  control FSM requests next instruction
- instr_ack  in  1  decode has consumed IR; releases the held instruction
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  WIDTH  byte target PC for the redirect
- imem_adr  out  ADDR_W  word address to instruction memory = pc[ADDR_W+1:2]
- imem_data  in  WIDTH  combinational read data from instruction memory
- pc  out  WIDTH  byte PC of the instruction in IR (or being fetched)
- pc_plus4  out  WIDTH  pc + 4, for link/next-sequential use
- instr  out  WIDTH  instruction register
- instr_valid  out  1  IR holds a valid, unconsumed instruction
- fault  out  1  sticky fetch fault (misaligned or out-of-range PC)

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, instr=NOP (32'h00000013), instr_valid=0, fault=0. Reset released synchronously into IDLE. Reset mid-FETCH or mid-VALID aborts with no partial capture.
- States are IDLE, FETCH, VALID, FAULT.
- IDLE:
  - fetch_req=1 and PC legal -> FETCH.
  - fetch_req=1 and PC illegal -> FAULT.
- FETCH: imem_adr is valid for the full cycle. At the next edge, instr <= imem_data, instr_valid <= 1, go to VALID. Latency from fetch_req in IDLE to instr_valid is 2 edges.
- VALID: instr and pc are held stable while instr_ack=0 (stall, unbounded). On instr_ack=1:
  - instr_valid <= 0.
  - pc <= redirect_valid ? redirect_pc : pc+4.
  - Go to IDLE, or to FAULT if the new PC is illegal.
- Redirect in IDLE: pc <= redirect_pc; stay in IDLE, or go to FAULT if the PC is illegal. If fetch_req is also asserted, the redirect wins and the fetch starts in the following cycle.
- Redirect in FETCH: the capture is discarded, pc <= redirect_pc, and the state goes to IDLE (or FAULT). Redirect has priority over capture.
- Illegal PC: pc[1:0] != 0, or pc[ADDR_W+1:2] >= IMEM_DEPTH, or pc[WIDTH-1:ADDR_W+2] != 0.
- FAULT:
  - fault=1, instr=NOP, instr_valid=0.
  - All inputs are ignored; only reset exits this state.
- pc+4 wraps modulo 2^WIDTH. The wrapped value falls under the out-of-range rule.
- imem_adr always equals pc[ADDR_W+1:2], including in IDLE and VALID. It is glitch-free because it is registered via pc.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined:
  - Adds outputs fetch_cnt[31:0] and stall_cnt[31:0].
  - fetch_cnt increments on each FETCH->VALID capture.
  - stall_cnt increments on each VALID cycle with instr_ack=0.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: neither the ports nor the logic exist; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, FETCH, VALID, FAULT}
  - NOP_INSTR = 32'h00000013
  - function pc_legal(pc) parameterised by ADDR_W and IMEM_DEPTH
- One sub-module is natural: fetch_perf_cnt, a saturating counter pair instantiated only under FETCH_PERF_EN. Everything else stays flat.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> pc=0, imem_adr=0, instr=32'h00000013, instr_valid=0, fault=0.
- Sequential fetch:
  - Stimulus: fetch_req pulse with imem_data=32'h00700093 at adr 0.
  - Response: 2 edges later instr=32'h00700093, instr_valid=1.
  - After instr_ack: pc=4, imem_adr=1.
- Stall: hold instr_ack=0 for 5 cycles in VALID -> instr and pc unchanged, stall_cnt=5 under FETCH_PERF_EN. On ack, pc advances by exactly 4.
- Redirect: in VALID at pc=0x14, apply instr_ack=1 with redirect_valid=1 and redirect_pc=0x08 -> pc=0x08, imem_adr=2. Redirect asserted during FETCH -> no capture, instr_valid stays 0.
- Fault:
  - redirect_pc=0x30 (word 12) -> fault=1 and state FAULT. Further fetch_req is ignored until rst=0.
  - redirect_pc=0x06 (misaligned) -> fault=1.
- Async reset mid-FETCH: drop rst between edges -> outputs go to reset values immediately, without waiting for a clock edge.
